// File: rtl/sgpio_rx_decoder_if.sv
// SGPIO target bundle: serial stream from the initiator plus the decoded LED/status outputs.
interface sgpio_rx_decoder_if #(
  parameter int HDD_NUM = 36
);
  logic               SGPIO_CK;
  logic               SGPIO_LD;
  logic               SGPIO_DATA;
  logic [HDD_NUM-1:0] DRV_ACT_LED_N;
  logic [HDD_NUM-1:0] DRV_LOC_LED;
  logic [HDD_NUM-1:0] DRV_FAIL_LED;
  logic               LINK_OK;
  logic               FRAME_ERR;
  logic [7:0]         ERR_CNT;

  modport master (
    output SGPIO_CK, SGPIO_LD, SGPIO_DATA,
    input  DRV_ACT_LED_N, DRV_LOC_LED, DRV_FAIL_LED, LINK_OK, FRAME_ERR, ERR_CNT
  );

  modport slave (
    input  SGPIO_CK, SGPIO_LD, SGPIO_DATA,
    output DRV_ACT_LED_N, DRV_LOC_LED, DRV_FAIL_LED, LINK_OK, FRAME_ERR, ERR_CNT
  );
endinterface

// File: rtl/sgpio_rx_decoder.sv
// Backplane SGPIO target: oversamples CK/LD/DATA, deserialises 3 bits per drive and
// commits whole frames atomically to the LED outputs, with link timeout and error stats.
module sgpio_rx_decoder #(
  parameter int HDD_NUM     = 36,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                SYSCLK,
  input  logic                RESET_N,
  sgpio_rx_decoder_if.slave   sgpio
);

  localparam int FW = 3 * HDD_NUM;
  localparam int CW = $clog2(FW + 2);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FW);
  localparam logic [CW-1:0] CNT_MAX  = CW'(FW + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] TO_HOLD  = TW'(TIMEOUT_CYC);

  typedef enum logic {ALIGN, SHIFT} state_t;

  logic [1:0] ck_sync_reg, ld_sync_reg, data_sync_reg;
  logic       ck_dly_reg;
  logic       strobe, ld_s, data_s;

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      ck_sync_reg   <= '0;
      ld_sync_reg   <= '0;
      data_sync_reg <= '0;
      ck_dly_reg    <= 1'b0;
    end else begin
      ck_sync_reg   <= {ck_sync_reg[0], sgpio.SGPIO_CK};
      ld_sync_reg   <= {ld_sync_reg[0], sgpio.SGPIO_LD};
      data_sync_reg <= {data_sync_reg[0], sgpio.SGPIO_DATA};
      ck_dly_reg    <= ck_sync_reg[1];
    end
  end

  // Falling CK edge lands mid-bit, where LD/DATA are stable.
  assign strobe = ck_dly_reg & ~ck_sync_reg[1];
  assign ld_s   = ld_sync_reg[1];
  assign data_s = data_sync_reg[1];

  state_t             state_reg, state_next;
  logic [CW-1:0]      cnt_reg, cnt_next, cnt_inc;
  logic [FW-1:0]      shift_reg, shift_next, shift_in;
  logic [TW-1:0]      to_reg, to_next;
  logic [HDD_NUM-1:0] act_n_reg, act_n_next;
  logic [HDD_NUM-1:0] loc_reg, loc_next;
  logic [HDD_NUM-1:0] fail_reg, fail_next;
  logic               link_reg, link_next;
  logic               ferr_reg, ferr_next;
  logic [7:0]         errcnt_reg, errcnt_next;
  logic               timeout_hit;
  logic [HDD_NUM-1:0] act_bits, loc_bits, fail_bits;

  assign shift_in = {data_s, shift_reg[FW-1:1]};

  // Drive fields as they will sit once the current bit is shifted in.
  for (genvar gi = 0; gi < HDD_NUM; gi++) begin : g_fields
    assign act_bits[gi]  = shift_in[3*gi];
    assign loc_bits[gi]  = shift_in[3*gi+1];
    assign fail_bits[gi] = shift_in[3*gi+2];
  end

  assign cnt_inc     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
  assign timeout_hit = !strobe && (to_reg == TO_LAST);

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    shift_next  = shift_reg;
    act_n_next  = act_n_reg;
    loc_next    = loc_reg;
    fail_next   = fail_reg;
    link_next   = link_reg;
    ferr_next   = 1'b0;
    errcnt_next = errcnt_reg;
    to_next     = to_reg;

    if (strobe) begin
      to_next = '0;
    end else if (to_reg != TO_HOLD) begin
      to_next = to_reg + 1'b1;
    end

    case (state_reg)
      ALIGN: begin
        if (strobe && ld_s) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (strobe) begin
          shift_next = shift_in;
          cnt_next   = cnt_inc;
          if (ld_s) begin
            cnt_next = '0;
            if (cnt_inc == CNT_FULL) begin
              act_n_next = ~act_bits;
              loc_next   = loc_bits;
              fail_next  = fail_bits;
              link_next  = 1'b1;
            end else begin
              ferr_next = 1'b1;
              if (errcnt_reg != 8'hFF) errcnt_next = errcnt_reg + 8'd1;
            end
          end
        end
      end
      default: state_next = ALIGN;
    endcase

    if (timeout_hit) begin
      state_next = ALIGN;
      cnt_next   = '0;
      link_next  = 1'b0;
      act_n_next = '1;
      loc_next   = '0;
      fail_next  = '0;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (!RESET_N) begin
      state_reg  <= ALIGN;
      cnt_reg    <= '0;
      shift_reg  <= '0;
      to_reg     <= '0;
      act_n_reg  <= '1;
      loc_reg    <= '0;
      fail_reg   <= '0;
      link_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      errcnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      shift_reg  <= shift_next;
      to_reg     <= to_next;
      act_n_reg  <= act_n_next;
      loc_reg    <= loc_next;
      fail_reg   <= fail_next;
      link_reg   <= link_next;
      ferr_reg   <= ferr_next;
      errcnt_reg <= errcnt_next;
    end
  end

  assign sgpio.DRV_ACT_LED_N = act_n_reg;
  assign sgpio.DRV_LOC_LED   = loc_reg;
  assign sgpio.DRV_FAIL_LED  = fail_reg;
  assign sgpio.LINK_OK       = link_reg;
  assign sgpio.FRAME_ERR     = ferr_reg;
  assign sgpio.ERR_CNT       = errcnt_reg;

endmodule

// File: tb/tb_sgpio_rx_decoder.sv
// Scoreboard bench for sgpio_rx_decoder: frames push expected LED/status state, checked after each LD bit.
module tb_sgpio_rx_decoder;
  localparam int N  = 4;
  localparam int TO = 200;

  logic SYSCLK  = 1'b0;
  logic RESET_N = 1'b0;

  sgpio_rx_decoder_if #(.HDD_NUM(N)) bus ();

  sgpio_rx_decoder #(.HDD_NUM(N), .TIMEOUT_CYC(TO)) dut (
    .SYSCLK (SYSCLK),
    .RESET_N(RESET_N),
    .sgpio  (bus)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic [N-1:0] act_n;
    logic [N-1:0] loc;
    logic [N-1:0] fail;
    logic         link;
    logic [7:0]   errs;
    int           fe;
  } exp_t;

  exp_t sb_q[$];
  exp_t m;
  bit   m_aligned;
  int   total = 0;
  int   bad   = 0;
  int   fe_seen = 0;
  int   frame_no = 0;

  always @(negedge SYSCLK) if (bus.FRAME_ERR === 1'b1) fe_seen++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check_val({tag, ".act_n"}, 32'(bus.DRV_ACT_LED_N), 32'(e.act_n));
    check_val({tag, ".loc"},   32'(bus.DRV_LOC_LED),   32'(e.loc));
    check_val({tag, ".fail"},  32'(bus.DRV_FAIL_LED),  32'(e.fail));
    check_val({tag, ".link"},  32'(bus.LINK_OK),       32'(e.link));
    check_val({tag, ".errs"},  32'(bus.ERR_CNT),       32'(e.errs));
  endtask

  task automatic model_reset;
    m.act_n   = '1;
    m.loc     = '0;
    m.fail    = '0;
    m.link    = 1'b0;
    m.errs    = '0;
    m_aligned = 1'b0;
  endtask

  // One bit: CK high for 10 cycles then low for 10; the falling edge is the sample point.
  task automatic send_bit(input logic d, input logic ld, input exp_t pre);
    exp_t e;
    bus.SGPIO_CK   = 1'b1;
    bus.SGPIO_DATA = d;
    bus.SGPIO_LD   = ld;
    repeat (10) tick;
    bus.SGPIO_CK = 1'b0;
    if (ld) begin
      tick;
      tick;
      check_outputs("pre_commit", pre);
      tick;
      if (sb_q.size() == 0) begin
        check_val("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check_outputs("post_frame", e);
        repeat (7) tick;
        check_val("frame_err_pulses", 32'(fe_seen), 32'(e.fe));
      end
    end else begin
      repeat (10) tick;
    end
  endtask

  function automatic logic [15:0] enc(input logic [3:0] a, input logic [3:0] l, input logic [3:0] f);
    logic [15:0] b;
    b = '0;
    for (int d = 0; d < N; d++) begin
      b[3*d]   = a[d];
      b[3*d+1] = l[d];
      b[3*d+2] = f[d];
    end
    return b;
  endfunction

  task automatic send_frame(input logic [15:0] bits, input int len);
    exp_t pre;
    pre = m;
    if (!m_aligned) begin
      m_aligned = 1'b1;
    end else if (len == 3*N) begin
      for (int d = 0; d < N; d++) begin
        m.act_n[d] = ~bits[3*d];
        m.loc[d]   = bits[3*d+1];
        m.fail[d]  = bits[3*d+2];
      end
      m.link = 1'b1;
    end else begin
      if (m.errs != 8'hFF) m.errs = m.errs + 8'd1;
      m.fe++;
    end
    sb_q.push_back(m);
    frame_no++;
    $display("frame %0d: len=%0d bits=%h exp act_n=%h loc=%h fail=%h link=%0b errs=%0d",
             frame_no, len, bits, m.act_n, m.loc, m.fail, m.link, m.errs);
    for (int i = 0; i < len; i++) send_bit(bits[i], (i == len - 1), pre);
  endtask

  initial begin
    logic [15:0] b;
    bus.SGPIO_CK   = 1'b0;
    bus.SGPIO_LD   = 1'b0;
    bus.SGPIO_DATA = 1'b0;
    m.fe = 0;
    model_reset();

    repeat (3) tick;
    check_outputs("reset", m);
    check_val("reset.frame_err", 32'(bus.FRAME_ERR), 32'd0);
    RESET_N = 1'b1;
    tick;

    send_frame(16'($urandom), 12);
    send_frame(enc(4'b0101, 4'b1000, 4'b0010), 12);
    check_val("good.act_n_const", 32'(bus.DRV_ACT_LED_N), 32'h0000000A);
    send_frame(16'($urandom), 11);
    send_frame(enc(4'b1100, 4'b0011, 4'b1001), 12);
    send_frame(16'($urandom), 14);
    check_val("long.errs_const", 32'(bus.ERR_CNT), 32'd2);

    $display("timeout: CK stopped");
    repeat (192) tick;
    check_val("timeout.link_before", 32'(bus.LINK_OK), 32'd1);
    tick;
    model_reset();
    m.errs = 8'd2;
    check_outputs("timeout", m);
    repeat (46) tick;
    check_outputs("timeout_hold", m);

    send_frame(enc(4'b1111, 4'b0000, 4'b0000), 12);
    send_frame(enc(4'b0011, 4'b0101, 4'b1110), 12);

    $display("reset mid-frame at bit 6");
    b = enc(4'b1010, 4'b1111, 4'b0001);
    for (int i = 0; i < 6; i++) send_bit(b[i], 1'b0, m);
    RESET_N = 1'b0;
    tick;
    RESET_N = 1'b1;
    model_reset();
    check_outputs("mid_reset", m);
    send_frame(b >> 6, 6);
    send_frame(enc(4'b0110, 4'b1001, 4'b0100), 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
